// File: rtl/memory_block_server.sv
// memory_block_server: fixed-latency aligned block refill responder with single-word writes; ports clk/rst, memRead/memWrite/address/dataIn in, dataRtoC/adr0..adr3/memReady/busy out; MEM_INIT_EN preloads mem[i]=i
module memory_block_server #(
  parameter int WORD = 32,
  parameter int ADDRESSL = 15,
  parameter int BLOCKL = 4,
  parameter int LATENCY = 4,
  parameter int MEMSIZE = 32768
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    memRead,
  input  logic                    memWrite,
  input  logic [ADDRESSL-1:0]     address,
  input  logic [WORD-1:0]         dataIn,
  output logic [BLOCKL*WORD-1:0]  dataRtoC,
  output logic [ADDRESSL-1:0]     adr0,
  output logic [ADDRESSL-1:0]     adr1,
  output logic [ADDRESSL-1:0]     adr2,
  output logic [ADDRESSL-1:0]     adr3,
  output logic                    memReady,
  output logic                    busy
);
  localparam int OFF = $clog2(BLOCKL);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, DELIVER = 2'd2;
  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [ADDRESSL-1:0] base_q, base_d;
  logic busy_q, rdy_q;
  logic [BLOCKL*WORD-1:0] data_q, blk;
  logic [3:0][ADDRESSL-1:0] adr_q;
`ifdef MEM_INIT_EN
  typedef logic [WORD-1:0] mem_t [MEMSIZE];
  function automatic mem_t init_mem();
    for (int i = 0; i < MEMSIZE; i++) init_mem[i] = WORD'(i);
  endfunction
  mem_t mem = init_mem();
`else
  logic [WORD-1:0] mem [MEMSIZE];
`endif
  wire accept = state_q == IDLE && memRead;
  always_comb begin
    state_d = state_q == IDLE ? (memRead ? WAIT : IDLE) : state_q == WAIT ? (cnt_q == 8'd0 ? DELIVER : WAIT) : IDLE;
    cnt_d = accept ? 8'(LATENCY - 1) : (state_q == WAIT && cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
    base_d = accept ? {address[ADDRESSL-1:OFF], {OFF{1'b0}}} : base_q;
  end
  for (genvar k = 0; k < BLOCKL; k++) begin : g_blk
    assign blk[k*WORD +: WORD] = mem[base_q | ADDRESSL'(k)];
  end
  // A write accepted alongside a read lands before DELIVER samples the array, so the fill sees it.
  always_ff @(posedge clk) begin
    if (!rst && state_q == IDLE && memWrite) mem[address] <= dataIn;
  end
  // busy rises one edge after acceptance and drops on the DELIVER edge, together with the memReady pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      base_q <= '0;
      busy_q <= 1'b0;
      rdy_q <= 1'b0;
      data_q <= '0;
      adr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      base_q <= base_d;
      busy_q <= state_q == WAIT;
      rdy_q <= state_q == DELIVER;
      if (state_q == DELIVER) begin
        data_q <= blk;
        for (int k = 0; k < 4; k++) adr_q[k] <= base_q | ADDRESSL'(k);
      end
    end
  end
  assign dataRtoC = data_q;
  assign {adr3, adr2, adr1, adr0} = adr_q;
  assign memReady = rdy_q;
  assign busy = busy_q;
endmodule
